// File: rtl/collision_engine.sv
// Lane-by-lane player/obstacle collision scanner with lives, grace window and game-over tracking.
// One lane is evaluated per cycle from values captured when the scan starts.
module collision_engine #(
  parameter int N_LANES      = 3,
  parameter int LANE_TOP0    = 0,
  parameter int LANE_PITCH   = 40,
  parameter int LANE_H       = 35,
  parameter int LOW_OFS      = 15,
  parameter int OBS_X        = 25,
  parameter int OBS_W        = 6,
  parameter int PLAYER_W     = 5,
  parameter int PLAYER_H     = 7,
  parameter int LIVES        = 3,
  parameter int GRACE_FRAMES = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [7:0]             curr_x,
  input  logic [6:0]             curr_y,
  input  logic                   crouch,
  input  logic [2*N_LANES-1:0]   lanes,
  input  logic                   clear_game,
  output logic                   busy,
  output logic                   done,
  output logic                   collision,
  output logic [2:0]             hit_lane,
  output logic                   counted,
  output logic [3:0]             lives_left,
  output logic                   grace,
  output logic                   game_over,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [2:0]  LAST_LANE  = 3'(N_LANES - 1);
  localparam logic [15:0] OBS_RIGHT  = 16'(OBS_X + OBS_W - 1);
  localparam logic [15:0] OBS_LEFT   = 16'(OBS_X);
  localparam logic [15:0] P_W_M1     = 16'(PLAYER_W - 1);
  localparam logic [15:0] P_H_M1     = 16'(PLAYER_H - 1);
  localparam logic [3:0]  LIVES_INIT = 4'(LIVES);
  localparam logic [7:0]  GRACE_INIT = 8'(GRACE_FRAMES);

  state_t state, state_nx;

  logic [7:0]           cap_x;
  logic [6:0]           cap_y;
  logic                 cap_crouch;
  logic [2*N_LANES-1:0] cap_lanes;
  logic [2:0]           lane_cnt;
  logic                 acc_hit;
  logic [2:0]           acc_lane;
  logic [7:0]           grace_cnt;

  logic [15:0] px, py;
  logic [15:0] lane_top, lane_bot, band_top;
  logic [1:0]  code;
  logic        code_active, x_ovl, y_ovl, lane_hit;

  // Handshake: start is a one-cycle request honoured only in IDLE (busy=0);
  // requests while busy are dropped, and each accepted start yields exactly one done pulse.
  assign busy      = (state != IDLE);
  assign grace     = (grace_cnt != 8'd0);
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN:    if (lane_cnt == LAST_LANE) state_nx = REPORT;
      REPORT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // 16-bit geometry keeps every edge sum clear of wrap-around at the input extremes.
  always_comb begin
    px          = {8'd0, cap_x};
    py          = {9'd0, cap_y};
    lane_top    = 16'(LANE_TOP0) + 16'(lane_cnt) * 16'(LANE_PITCH);
    lane_bot    = lane_top + 16'(LANE_H);
    code        = cap_lanes[{lane_cnt, 1'b0} +: 2];
    band_top    = (code == 2'b01) ? lane_top + 16'(LOW_OFS) : lane_top;
    code_active = (code == 2'b01) || (code == 2'b11) || ((code == 2'b10) && !cap_crouch);
    x_ovl       = (px <= OBS_RIGHT) && ((px + P_W_M1) >= OBS_LEFT);
    y_ovl       = (py <= lane_bot) && ((py + P_H_M1) >= band_top);
    lane_hit    = code_active && x_ovl && y_ovl;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cap_x      <= 8'd0;
      cap_y      <= 7'd0;
      cap_crouch <= 1'b0;
      cap_lanes  <= '0;
      lane_cnt   <= 3'd0;
      acc_hit    <= 1'b0;
      acc_lane   <= 3'd0;
      done       <= 1'b0;
      collision  <= 1'b0;
      hit_lane   <= 3'd0;
      counted    <= 1'b0;
      lives_left <= LIVES_INIT;
      grace_cnt  <= 8'd0;
      game_over  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cap_x      <= curr_x;
            cap_y      <= curr_y;
            cap_crouch <= crouch;
            cap_lanes  <= lanes;
            lane_cnt   <= 3'd0;
            acc_hit    <= 1'b0;
            acc_lane   <= 3'd0;
          end
        end
        SCAN: begin
          if (lane_hit && !acc_hit) begin
            acc_hit  <= 1'b1;
            acc_lane <= lane_cnt;
          end
          if (lane_cnt != LAST_LANE) lane_cnt <= lane_cnt + 3'd1;
        end
        REPORT: begin
          done      <= 1'b1;
          collision <= acc_hit;
          hit_lane  <= acc_hit ? acc_lane : 3'd0;
          counted   <= 1'b0;
          if (grace_cnt != 8'd0) begin
            grace_cnt <= grace_cnt - 8'd1;
          end else if (acc_hit && !game_over && !clear_game) begin
            counted    <= 1'b1;
            lives_left <= lives_left - 4'd1;
            grace_cnt  <= GRACE_INIT;
            if (lives_left == 4'd1) game_over <= 1'b1;
          end
        end
        default: ;
      endcase
      // A restart of the game overrides whatever the report would have done to lives.
      if (clear_game) begin
        lives_left <= LIVES_INIT;
        game_over  <= 1'b0;
        grace_cnt  <= 8'd0;
      end
    end
  end

endmodule
